// File: rtl/arduino_spi_adc_model.sv
// Behavioural multi-channel SPI ADC: decodes a channel command byte and returns that channel's
// bench-supplied sample on MISO in any SPI mode, with frame/abort/error counters for checking.
module arduino_spi_adc_model #(
    parameter int unsigned NUM_CH      = 8,
    parameter int unsigned ADC_BITS    = 12,
    parameter bit          CPOL        = 1'b0,
    parameter bit          CPHA        = 1'b0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic                       SPI_CS_N,
    input  logic                       SPI_SCK,
    input  logic                       SPI_MOSI,
    output logic                       SPI_MISO,
    output logic                       SPI_MISO_OE,
    input  logic [NUM_CH*ADC_BITS-1:0] CH_DATA,
    output logic [15:0]                FRAME_COUNT,
    output logic [7:0]                 ABORT_COUNT,
    output logic                       CMD_ERR
);

    localparam logic [2:0] StWaitIdle = 3'd0;
    localparam logic [2:0] StIdle     = 3'd1;
    localparam logic [2:0] StCmd      = 3'd2;
    localparam logic [2:0] StData     = 3'd3;
    localparam logic [2:0] StDone     = 3'd4;
    localparam logic [2:0] StErr      = 3'd5;

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sck_prev_q;
    logic                   sck_s, cs_s, mosi_s;
    logic                   sck_rise, sck_fall, sample_edge, shift_edge;

    logic [2:0]  state_q, state_d;
    logic [4:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [15:0] shreg_q, shreg_d;
    logic        miso_q, miso_d;
    logic        oe_q, oe_d;
    logic [15:0] frame_q, frame_d;
    logic [7:0]  abort_q, abort_d;
    logic        err_q, err_d;
    logic [ADC_BITS-1:0] sample;

    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;
    assign sample_edge = (CPOL == CPHA) ? sck_rise : sck_fall;
    assign shift_edge  = (CPOL == CPHA) ? sck_fall : sck_rise;

    always_comb begin
        sample = '0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (cmd_q[3:0] == i[3:0]) begin
                sample = CH_DATA[i*ADC_BITS +: ADC_BITS];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        cmd_d     = cmd_q;
        shreg_d   = shreg_q;
        miso_d    = 1'b0;
        frame_d   = frame_q;
        abort_d   = abort_q;
        err_d     = err_q;

        if (sample_edge && (state_q == StCmd || state_q == StData)) begin
            bit_cnt_d = bit_cnt_q + 5'd1;
        end

        case (state_q)
            StWaitIdle: if (cs_s) state_d = StIdle;
            StIdle: begin
                if (!cs_s) begin
                    state_d   = StCmd;
                    bit_cnt_d = '0;
                end
            end
            StCmd: begin
                if (cs_s) begin
                    state_d = StIdle;
                    if (abort_q != 8'hFF) abort_d = abort_q + 8'd1;
                end else begin
                    if (sample_edge) cmd_d = {cmd_q[6:0], mosi_s};
                    if (bit_cnt_q == 5'd8) begin
                        if (!cmd_q[7]) begin
                            state_d = StErr;
                            err_d   = 1'b1;
                        end else if ({28'd0, cmd_q[3:0]} >= NUM_CH) begin
                            state_d = StData;
                            shreg_d = 16'hFFFF;
                            err_d   = 1'b1;
                        end else begin
                            state_d = StData;
                            shreg_d = 16'(sample);
                        end
                    end
                end
            end
            StData: begin
                if (cs_s) begin
                    state_d = StIdle;
                    // A CS rise coinciding with the final sample edge still completes the frame.
                    if (bit_cnt_q == 5'd24 || (sample_edge && bit_cnt_q == 5'd23)) begin
                        frame_d = frame_q + 16'd1;
                    end else if (abort_q != 8'hFF) begin
                        abort_d = abort_q + 8'd1;
                    end
                end else if (bit_cnt_q == 5'd24) begin
                    state_d = StDone;
                    frame_d = frame_q + 16'd1;
                end else begin
                    miso_d = miso_q;
                    if (shift_edge) miso_d = shreg_q[4'(5'd23 - bit_cnt_q)];
                end
            end
            StDone, StErr: if (cs_s) state_d = StIdle;
            default: state_d = StWaitIdle;
        endcase

        oe_d = !cs_s && (state_d != StWaitIdle);
    end

    // CS_N synchroniser resets to "selected" so WAIT_IDLE must see a real high before leaving.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            sck_sync_q  <= {SYNC_STAGES{CPOL}};
            cs_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= CPOL;
            state_q     <= StWaitIdle;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            shreg_q     <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
            frame_q     <= '0;
            abort_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS_N};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
            sck_prev_q  <= sck_s;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            shreg_q     <= shreg_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
            frame_q     <= frame_d;
            abort_q     <= abort_d;
            err_q       <= err_d;
        end
    end

    assign SPI_MISO    = miso_q;
    assign SPI_MISO_OE = oe_q;
    assign FRAME_COUNT = frame_q;
    assign ABORT_COUNT = abort_q;
    assign CMD_ERR     = err_q;

endmodule

// File: tb/tb_arduino_spi_adc_model.sv
// Directed bench: one ADC model per SPI mode (index = {CPOL,CPHA}), each with its own CS_N/SCK.
module tb_arduino_spi_adc_model;

    localparam int NCH = 8;
    localparam int AB  = 12;
    localparam int H   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [3:0]        cs_n, sck, miso, oe, err;
    logic              mosi;
    logic [NCH*AB-1:0] ch_data, ch_init;
    logic [15:0]       fc [4];
    logic [7:0]        ac [4];

    int total = 0;
    int bad   = 0;

    logic [15:0] rd;
    int          un, chi, ol, pr;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        arduino_spi_adc_model #(
            .NUM_CH(NCH), .ADC_BITS(AB), .CPOL(((g >> 1) & 1) == 1), .CPHA((g & 1) == 1),
            .SYNC_STAGES(2)
        ) u_dut (
            .CLK(clk), .RESET(rst), .SPI_CS_N(cs_n[g]), .SPI_SCK(sck[g]), .SPI_MOSI(mosi),
            .SPI_MISO(miso[g]), .SPI_MISO_OE(oe[g]), .CH_DATA(ch_data),
            .FRAME_COUNT(fc[g]), .ABORT_COUNT(ac[g]), .CMD_ERR(err[g])
        );
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst  = 1'b1;
        cs_n = 4'hF;
        sck  = 4'b1100;
        mosi = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        wait_clk(6);
    endtask

    // Master-side frame driver; reports the data field and observations taken at sample points.
    task automatic spi_frame(input int m, input logic [7:0] cmd, input int nbits,
                             input int rst_bit, input int chg_bit, input bit cs_last,
                             output logic [15:0] rdata, output int unstable, output int cmd_hi,
                             output int oe_lo, output int post_rst);
        bit   cpol, cpha;
        logic v0, dbit;
        cpol = ((m >> 1) & 1) == 1;
        cpha = (m & 1) == 1;
        rdata = '0; unstable = 0; cmd_hi = 0; oe_lo = 0; post_rst = 0;
        @(negedge clk);
        cs_n[m] = 1'b0;
        wait_clk(H);
        for (int i = 0; i < nbits; i++) begin
            dbit = (i < 8) ? cmd[7-i] : 1'b0;
            if (cpha) sck[m] = ~cpol;
            mosi = dbit;
            wait_clk(H);
            v0 = miso[m];
            if (i >= 8) rdata = {rdata[14:0], v0};
            if (i < 8 && v0 !== 1'b0) cmd_hi++;
            if (rst_bit < 0 || i <= rst_bit) begin
                if (oe[m] !== 1'b1) oe_lo++;
            end else if (oe[m] !== 1'b0 || v0 !== 1'b0) begin
                post_rst++;
            end
            sck[m] = cpha ? cpol : ~cpol;
            if (cs_last && i == nbits - 1) begin
                cs_n[m] = 1'b1;
                wait_clk(H);
                return;
            end
            wait_clk(2);
            if (miso[m] !== v0) unstable++;
            if (i == rst_bit) begin
                rst = 1'b1;
                wait_clk(2);
                rst = 1'b0;
                wait_clk(H - 4);
            end else begin
                wait_clk(H - 2);
            end
            if (i == chg_bit) ch_data = ~ch_data;
            if (!cpha) sck[m] = cpol;
        end
        wait_clk(H);
        cs_n[m] = 1'b1;
        wait_clk(H);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        wait_clk(3);
        for (int m = 0; m < 4; m++) begin
            total++; if (miso[m] !== 1'b0) begin bad++; $display("FAIL rst_miso[%0d]: got %b want 0", m, miso[m]); end
            total++; if (oe[m] !== 1'b0) begin bad++; $display("FAIL rst_oe[%0d]: got %b want 0", m, oe[m]); end
            total++; if (fc[m] !== 16'h0) begin bad++; $display("FAIL rst_fc[%0d]: got %h want 0", m, fc[m]); end
            total++; if (ac[m] !== 8'h0) begin bad++; $display("FAIL rst_ac[%0d]: got %h want 0", m, ac[m]); end
            total++; if (err[m] !== 1'b0) begin bad++; $display("FAIL rst_err[%0d]: got %b want 0", m, err[m]); end
        end
        rst = 1'b0;
        wait_clk(6);
    endtask

    task automatic test_mode0();
        do_reset();
        spi_frame(0, 8'h83, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h0A5C) begin bad++; $display("FAIL m0_data: got %h want 0a5c", rd); end
        total++; if (fc[0] !== 16'd1) begin bad++; $display("FAIL m0_fc: got %h want 1", fc[0]); end
        total++; if (err[0] !== 1'b0) begin bad++; $display("FAIL m0_err: got %b want 0", err[0]); end
        total++; if (ac[0] !== 8'd0) begin bad++; $display("FAIL m0_ac: got %h want 0", ac[0]); end
        total++; if (chi !== 0) begin bad++; $display("FAIL m0_cmd_miso: got %0d want 0", chi); end
        total++; if (ol !== 0) begin bad++; $display("FAIL m0_oe_low: got %0d want 0", ol); end
        total++; if (un !== 0) begin bad++; $display("FAIL m0_stable: got %0d want 0", un); end
        total++; if (oe[0] !== 1'b0) begin bad++; $display("FAIL m0_oe_after: got %b want 0", oe[0]); end
    endtask

    task automatic test_modes();
        do_reset();
        for (int m = 1; m < 4; m++) begin
            spi_frame(m, 8'h83, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
            total++; if (rd !== 16'h0A5C) begin bad++; $display("FAIL mode%0d_data: got %h want 0a5c", m, rd); end
            total++; if (un !== 0) begin bad++; $display("FAIL mode%0d_stable: got %0d want 0", m, un); end
            total++; if (fc[m] !== 16'd1) begin bad++; $display("FAIL mode%0d_fc: got %h want 1", m, fc[m]); end
        end
    endtask

    task automatic test_bad_start();
        do_reset();
        spi_frame(0, 8'h03, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h0 || chi !== 0) begin bad++; $display("FAIL bs_miso: got %h/%0d want 0/0", rd, chi); end
        total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL bs_err: got %b want 1", err[0]); end
        total++; if (fc[0] !== 16'd0) begin bad++; $display("FAIL bs_fc: got %h want 0", fc[0]); end
        spi_frame(0, 8'h83, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h0A5C) begin bad++; $display("FAIL bs_next: got %h want 0a5c", rd); end
        total++; if (fc[0] !== 16'd1) begin bad++; $display("FAIL bs_next_fc: got %h want 1", fc[0]); end
        total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL bs_sticky: got %b want 1", err[0]); end
    endtask

    task automatic test_bad_channel();
        do_reset();
        spi_frame(0, 8'h8A, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'hFFFF) begin bad++; $display("FAIL bc_data: got %h want ffff", rd); end
        total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL bc_err: got %b want 1", err[0]); end
        total++; if (fc[0] !== 16'd1) begin bad++; $display("FAIL bc_fc: got %h want 1", fc[0]); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        // Bits 6:4 set: still channel 7, the top valid channel.
        spi_frame(3, 8'hF7, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h07E1) begin bad++; $display("FAIL b2b_ch7: got %h want 07e1", rd); end
        spi_frame(3, 8'h80, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h0123) begin bad++; $display("FAIL b2b_ch0: got %h want 0123", rd); end
        total++; if (fc[3] !== 16'd2) begin bad++; $display("FAIL b2b_fc: got %h want 2", fc[3]); end
        total++; if (err[3] !== 1'b0) begin bad++; $display("FAIL b2b_err: got %b want 0", err[3]); end
    endtask

    task automatic test_abort();
        do_reset();
        spi_frame(2, 8'h83, 12, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (ac[2] !== 8'd1) begin bad++; $display("FAIL ab_ac: got %h want 1", ac[2]); end
        total++; if (fc[2] !== 16'd0) begin bad++; $display("FAIL ab_fc0: got %h want 0", fc[2]); end
        spi_frame(2, 8'h80, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h0123) begin bad++; $display("FAIL ab_data: got %h want 0123", rd); end
        total++; if (fc[2] !== 16'd1) begin bad++; $display("FAIL ab_fc1: got %h want 1", fc[2]); end
        for (int n = 2; n <= 300; n++) begin
            cs_n[2] = 1'b0;
            wait_clk(H);
            cs_n[2] = 1'b1;
            wait_clk(H);
            if (n == 254) begin
                total++; if (ac[2] !== 8'hFE) begin bad++; $display("FAIL ab_254: got %h want fe", ac[2]); end
            end
            if (n == 255 || n == 300) begin
                total++; if (ac[2] !== 8'hFF) begin bad++; $display("FAIL ab_sat%0d: got %h want ff", n, ac[2]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        spi_frame(0, 8'h83, 24, 12, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (pr !== 0) begin bad++; $display("FAIL rm_drive: got %0d want 0", pr); end
        total++; if (fc[0] !== 16'd0) begin bad++; $display("FAIL rm_fc: got %h want 0", fc[0]); end
        total++; if (ac[0] !== 8'd0) begin bad++; $display("FAIL rm_ac: got %h want 0", ac[0]); end
        spi_frame(0, 8'h83, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h0A5C) begin bad++; $display("FAIL rm_next: got %h want 0a5c", rd); end
        total++; if (fc[0] !== 16'd1) begin bad++; $display("FAIL rm_next_fc: got %h want 1", fc[0]); end
    endtask

    task automatic test_cs_at_last();
        do_reset();
        spi_frame(0, 8'h83, 24, -1, -1, 1'b1, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h0A5C) begin bad++; $display("FAIL cl_data: got %h want 0a5c", rd); end
        total++; if (fc[0] !== 16'd1) begin bad++; $display("FAIL cl_fc: got %h want 1", fc[0]); end
        total++; if (ac[0] !== 8'd0) begin bad++; $display("FAIL cl_ac: got %h want 0", ac[0]); end
    endtask

    task automatic test_data_hold();
        do_reset();
        spi_frame(1, 8'h83, 24, -1, 10, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h0A5C) begin bad++; $display("FAIL dh_inflight: got %h want 0a5c", rd); end
        spi_frame(1, 8'h83, 24, -1, -1, 1'b0, rd, un, chi, ol, pr);
        total++; if (rd !== 16'h05A3) begin bad++; $display("FAIL dh_new: got %h want 05a3", rd); end
        ch_data = ch_init;
    endtask

    initial begin
        rst  = 1'b1;
        cs_n = 4'hF;
        sck  = 4'b1100;
        mosi = 1'b0;
        for (int i = 0; i < NCH; i++) ch_init[i*AB +: AB] = 12'(i * 16 + 5);
        ch_init[0*AB +: AB] = 12'h123;
        ch_init[3*AB +: AB] = 12'hA5C;
        ch_init[7*AB +: AB] = 12'h7E1;
        ch_data = ch_init;
        wait_clk(2);
        test_reset();
        test_mode0();
        test_modes();
        test_bad_start();
        test_bad_channel();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        test_cs_at_last();
        test_data_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
